// File: rtl/fadd_issue_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fadd_issue_ctrl_if                                                   |
// | Request (dispatch) and result (writeback) handshake bundle for the   |
// | FP add issue controller.                                             |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface fadd_issue_ctrl_if #(
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic             in_sub;
   logic [31:0]      in_x;
   logic [31:0]      in_y;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;

   // dispatch/writeback side
   modport master (
      output in_valid, in_sub, in_x, in_y, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   // controller side
   modport slave (
      input  in_valid, in_sub, in_x, in_y, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
endinterface
`default_nettype wire

// File: rtl/fadd_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fadd_issue_ctrl                                                      |
// | Issue, valid/tag tracking and credit-based result buffering around   |
// | the stall-free pipelined FP adder fadd_pipe (also defined here).     |
// | Optional feature macro: FADD_ZERO_BYPASS_EN (exponent-0 operands are |
// | treated as zero and their result substituted at writeback).          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+

// Fixed-latency single-precision adder: no valid, no stall. Assumes hidden
// bit 1 on every operand; rounds to nearest even; no special-value handling.
module fadd_pipe #(
   parameter int LAT = 2
) (
   input  logic        clk,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic [31:0] res
);
   logic        swap;
   logic [31:0] a, b;
   logic [7:0]  ediff;
   logic [25:0] ma, mb;
   logic [26:0] sum;
   logic        s1_sign;
   logic [7:0]  s1_exp;
   logic [26:0] s1_sum;
   logic [4:0]  lz;
   logic [25:0] norm;
   logic [7:0]  exp_n, exp_f;
   logic        rnd, carry;
   logic [22:0] frac;
   logic [31:0] result;
   logic [31:0] dly [2:LAT];

   // align the smaller magnitude to the larger and add/subtract mantissas
   always_comb begin
      swap  = (y[30:0] > x[30:0]);
      a     = swap ? y : x;
      b     = swap ? x : y;
      ediff = a[30:23] - b[30:23];
      ma    = {1'b1, a[22:0], 2'b00};
      mb    = {1'b1, b[22:0], 2'b00} >> ediff;
      sum   = (a[31] ^ b[31]) ? ({1'b0, ma} - {1'b0, mb}) : ({1'b0, ma} + {1'b0, mb});
   end

   // normalise, round and pack the registered sum
   always_comb begin
      lz = 5'd0;
      for (int i = 0; i < 26; i++) begin
         if (s1_sum[i]) lz = 5'(25 - i);
      end
      if (s1_sum[26]) begin
         norm  = {s1_sum[26:2], s1_sum[1] | s1_sum[0]};
         exp_n = s1_exp + 8'd1;
      end else begin
         norm  = s1_sum[25:0] << lz;
         exp_n = s1_exp - {3'b000, lz};
      end
      rnd           = norm[1] & (norm[0] | norm[2]);
      {carry, frac} = {1'b0, norm[24:2]} + {23'd0, rnd};
      exp_f         = exp_n + {7'd0, carry};
      result        = norm[25] ? {s1_sign, exp_f, frac} : 32'd0;
   end

   // two compute stages followed by LAT-2 pure delay stages
   always_ff @(posedge clk) begin
      s1_sign <= a[31];
      s1_exp  <= a[30:23];
      s1_sum  <= sum;
      dly[2]  <= result;
      for (int i = 3; i <= LAT; i++) dly[i] <= dly[i-1];
   end

   assign res = dly[LAT];
endmodule

module fadd_issue_ctrl #(
   parameter int LAT   = 2,
   parameter int DEPTH = 8,
   parameter int TAG_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   fadd_issue_ctrl_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam int CW = $clog2(DEPTH + LAT + 2);

   logic             kill, acc, push, pop;
   logic [31:0]      y_adj;
   logic [31:0]      op_x, op_y;
   logic [LAT:0]     v;
   logic [TAG_W-1:0] tag_p [0:LAT];
   logic [31:0]      res, wr_data;
   logic [CW-1:0]    inflight;
   logic [OW-1:0]    occ;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [31:0]      mem_data [0:DEPTH-1];
   logic [TAG_W-1:0] mem_tag  [0:DEPTH-1];

   assign kill  = rst | flush;
   assign acc   = bus.in_valid & bus.in_ready;
   assign push  = v[LAT] & ~kill;
   assign pop   = bus.out_valid & bus.out_ready;
   assign y_adj = {bus.in_y[31] ^ bus.in_sub, bus.in_y[30:0]};

   // ops still in the adder must already own a FIFO slot
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= LAT; i++) inflight = inflight + CW'(v[i]);
   end

   assign bus.in_ready = ~kill & ((CW'(occ) + inflight) < CW'(DEPTH));

   // operand register: loads on accept, otherwise holds
   always_ff @(posedge clk) begin
      if (acc) begin
         op_x <= bus.in_x;
         op_y <= y_adj;
      end
   end

   // valid/tag pipe mirrors the adder latency and never stalls
   always_ff @(posedge clk) begin
      if (acc) tag_p[0] <= bus.in_tag;
      for (int i = 1; i <= LAT; i++) tag_p[i] <= tag_p[i-1];
      if (kill) v <= '0;
      else      v <= {v[LAT-1:0], acc};
   end

   fadd_pipe #(.LAT(LAT)) u_pipe (
      .clk (clk),
      .x   (op_x),
      .y   (op_y),
      .res (res)
   );

`ifdef FADD_ZERO_BYPASS_EN
   logic [LAT:0] byp;
   logic [31:0]  bval [0:LAT];
   logic         x_zero, y_zero, byp_now;
   logic [31:0]  bval_now;

   // zero operands: the adder cannot represent them, so pick the answer now
   always_comb begin
      x_zero  = (bus.in_x[30:23] == 8'd0);
      y_zero  = (bus.in_y[30:23] == 8'd0);
      byp_now = x_zero | y_zero;
      if (x_zero & y_zero) bval_now = {bus.in_x[31] & y_adj[31], 31'd0};
      else if (y_zero)     bval_now = bus.in_x;
      else                 bval_now = y_adj;
   end

   // bypass flag/value travel beside the valid/tag pipe
   always_ff @(posedge clk) begin
      if (acc) begin
         byp[0]  <= byp_now;
         bval[0] <= bval_now;
      end
      for (int i = 1; i <= LAT; i++) begin
         byp[i]  <= byp[i-1];
         bval[i] <= bval[i-1];
      end
   end

   assign wr_data = byp[LAT] ? bval[LAT] : res;
`else
   assign wr_data = res;
`endif

   // result storage; space is guaranteed by the credit check at issue
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= wr_data;
         mem_tag[wr_ptr]  <= tag_p[LAT];
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (kill) begin
         occ    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   occ <= occ + OW'(1);
            2'b01:   occ <= occ - OW'(1);
            default: ;
         endcase
      end
   end

   assign bus.out_valid = (occ != '0);
   assign bus.out_data  = bus.out_valid ? mem_data[rd_ptr] : 32'd0;
   assign bus.out_tag   = bus.out_valid ? mem_tag[rd_ptr]  : '0;
endmodule
`default_nettype wire

// File: doc/fadd_issue_ctrl.md
# fadd_issue_ctrl

Issue, tracking and writeback control for the fixed-latency pipelined FP add unit (`fadd_pipe`), which has no valid or stall logic.
- Accepts add/sub requests over a valid/ready handshake and folds subtraction into a sign flip of y.
- Carries a valid bit and destination tag alongside each operation through the unit's latency.
- Buffers results in a tag-carrying FIFO so downstream back-pressure never requires stalling the unit.
- Sits between the FPU dispatch stage and the register-file writeback arbiter.

## Interface
- `LAT`, 2: cycles from `fadd_pipe` operand inputs to valid `res`; must match the instantiated unit.
- `DEPTH`, 8: result FIFO entries; must be ≥ 2, power of two.
- `TAG_W`, 5: destination tag width.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous kill of all in-flight and buffered operations.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when high together with `in_valid`.
- `in_sub`  in  1  1 = x − y, 0 = x + y.
- `in_x`, `in_y`  in  32  IEEE-754 single operands.
- `in_tag`  in  TAG_W  destination tag.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_data`  out  32  result.
- `out_tag`  out  TAG_W  tag of result.

## Operation
- Accept: `acc = in_valid & in_ready`.
  - On `acc`, the operand register captures `in_x`, and `in_y` with bit 31 inverted when `in_sub`.
  - It also captures the tag and sets `v[0]=1`.
  - Otherwise `v[0]=0` and the data registers hold.
- Valid/tag pipe `v[0..LAT]` shifts every cycle unconditionally. The unit never stalls.
- The operand register drives `fadd_pipe` x/y directly.
- Writeback: when `v[LAT]=1`, `{res, tag[LAT]}` is written into the FIFO at the next edge.
  - Write space is guaranteed by credit.
  - Overflow is a design error; the bench asserts on it.
- Credit:
  - `inflight = popcount(v[0..LAT])`, range 0..LAT+1.
  - `in_ready = ~rst & ~flush & (occ + inflight < DEPTH)`.
  - This is conservative: a same-cycle pop is not credited, and no combinational path exists from `out_ready` to `in_ready`.
- FIFO: `occ` ranges 0..DEPTH; read/write pointers have log2(DEPTH) bits and wrap modulo DEPTH.
  - Simultaneous push and pop leaves `occ` unchanged.
  - Pop occurs on `out_valid & out_ready`.
  - `out_valid = (occ != 0)`.
  - `out_data`/`out_tag` present the head entry and are stable while `out_valid & ~out_ready`.
- Flush/reset: `v[*]` ← 0, `occ` ← 0, pointers ← 0.
  - Results of killed operations are never written, including one arriving on the flush edge.
  - A request presented in the flush cycle is not accepted.
- Ordering: results leave in acceptance order.

## Timing
- Reset values:
  - `in_ready`=0 during `rst`, then 1 from the first cycle after `rst` deasserts.
  - `out_valid`=0, `out_data`=0, `out_tag`=0.
- Latency: with the FIFO empty, a request accepted at edge t is written at edge t+LAT+1, so `out_valid` is high in the cycle after edge t+LAT+1. With LAT=2, that is 3 cycles.
- Throughput: 1 op/cycle sustained with `out_ready`=1 requires `DEPTH ≥ LAT+3`. The default of 8 meets this.
- Back-pressure: with `out_ready`=0, at most DEPTH operations are outstanding. `in_ready` drops when `occ + inflight` reaches DEPTH.

## Configuration
- `FADD_ZERO_BYPASS_EN` defined: operands with exponent 0 are treated as zero, because the unit assumes hidden bit 1. At acceptance, a bypass flag and bypass value are computed and carried beside `v`/tag.
  - y zero, x nonzero: result is x.
  - x zero, y nonzero: result is sign-adjusted y.
  - Both zero: result is `{sx & sy', 31'b0}`, where `sy'` is the sign-adjusted y.
  - At writeback, the bypass value replaces `res`. Latency is unchanged.
- Undefined: `res` is always written unmodified. The bypass registers are not built.

## Test plan
- Reset and single add: 0x3F800000 + 0x40000000 accepted with tag 3 → after 3 cycles, `out_valid`=1, `out_data`=0x40400000, `out_tag`=3.
- Subtract via sign flip: `in_sub`=1, 0x40400000 − 0x3F800000 → 0x40000000. Then 0x3F800000 − 0x3F800000 → 0x00000000.
- Back-pressure with DEPTH=8:
  - Hold `out_ready`=0 and stream requests.
  - Exactly 8 are accepted and `in_ready`=0 thereafter.
  - Release `out_ready`: 8 results drain in order, tags 0..7, then `in_ready` returns to 1.
- Full throughput: `out_ready`=1, 100 back-to-back requests → `in_valid` and `in_ready` both high every cycle after the first, 100 in-order results, no FIFO overflow.
- Flush mid-flight:
  - Accept 3 ops, assert `flush` one cycle later.
  - No results ever appear and `occ`=0.
  - A request in the flush cycle is not accepted.
  - The next accepted op produces its correct result 3 cycles later.
- `FADD_ZERO_BYPASS_EN`: 0x00000000 + 0x3FC00000 → 0x3FC00000. Also 0x80000000 − 0x00000000 → 0x80000000. With the macro undefined, the bench checks only non-zero-operand vectors.
